// File: rtl/fb_fetch_unit_pkg.sv
// Shared constants and types for the fetch front end.
package fb_fetch_unit_pkg;

    localparam int unsigned FB_32BITS   = 32;
    localparam logic [31:0] FB_NOP_INST = 32'h0000_0013;
    localparam logic [31:0] FB_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [FB_32BITS-1:0] pc;
        logic [FB_32BITS-1:0] inst;
    } fq_entry_t;

endpackage

// File: rtl/fb_sync_fifo.sv
// Synchronous FIFO with flush and occupancy count; Depth must be a power of 2.
module fb_sync_fifo #(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [Width-1:0]       data_i,
    input  logic                   pop_i,
    output logic [Width-1:0]       data_o,
    output logic [$clog2(Depth):0] count_o
);

    localparam int unsigned AddrW = $clog2(Depth);
    localparam logic [AddrW:0] Full = (AddrW + 1)'(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [AddrW-1:0] wptr_q, rptr_q;
    logic [AddrW:0]   cnt_q;
    logic             do_push, do_pop;

    assign do_push = push_i & (cnt_q != Full);
    assign do_pop  = pop_i & (cnt_q != '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else if (flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage needs no reset; occupancy alone decides validity.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wptr_q] <= data_i;
    end

    assign data_o  = mem_q[rptr_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/fb_fetch_unit.sv
// Instruction fetch front end: fetch PC, imem handshake, stale-response kill and fetch queue.
module fb_fetch_unit
    import fb_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = FB_RESET_PC,
    parameter int unsigned FQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        address_src,
    input  logic [31:0] predict_err_pc,
    input  logic        predict_valid,
    input  logic [31:0] predict_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    input  logic        if_ready
);

    localparam int unsigned CntW = $clog2(FQ_DEPTH) + 1;
    localparam logic [CntW:0] DepthW = (CntW + 1)'(FQ_DEPTH);

    logic [31:0]     pc_q, pc_d;
    logic [CntW-1:0] kill_q, kill_d;
    logic [CntW-1:0] outstanding, outstanding_d, fq_count;
    logic [CntW:0]   occupancy;
    logic [31:0]     pend_pc, target;
    logic            redirect, grant, fq_push, fq_pop, fq_nonempty;
    fq_entry_t       fq_in, fq_head;

    assign redirect  = address_src | predict_valid;
    assign target    = address_src ? predict_err_pc : predict_pc;
    assign occupancy = {1'b0, outstanding} + {1'b0, fq_count};
    assign imem_req  = rst_n & ~redirect & (occupancy < DepthW);
    assign imem_addr = pc_q;
    assign grant     = imem_req & imem_gnt;

    always_comb begin
        pc_d = pc_q;
        if (redirect)   pc_d = target;
        else if (grant) pc_d = pc_q + 32'd1;
    end

    always_comb begin
        outstanding_d = outstanding;
        if (grant && !imem_rvalid)      outstanding_d = outstanding + 1'b1;
        else if (!grant && imem_rvalid) outstanding_d = outstanding - 1'b1;
    end

    // Every response still in flight at a redirect belongs to the wrong path.
    always_comb begin
        kill_d = kill_q;
        if (redirect)                          kill_d = outstanding_d;
        else if (imem_rvalid && kill_q != '0)  kill_d = kill_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= RESET_PC;
            kill_q <= '0;
        end else begin
            pc_q   <= pc_d;
            kill_q <= kill_d;
        end
    end

    // The pending-PC FIFO occupancy is exactly the outstanding request count.
    fb_sync_fifo #(
        .Width (32),
        .Depth (FQ_DEPTH)
    ) u_pend_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .flush_i (1'b0),
        .push_i  (grant),
        .data_i  (pc_q),
        .pop_i   (imem_rvalid),
        .data_o  (pend_pc),
        .count_o (outstanding)
    );

    assign fq_push   = imem_rvalid & (kill_q == '0) & ~redirect;
    assign fq_in.pc   = pend_pc;
    assign fq_in.inst = imem_rdata;

    fb_sync_fifo #(
        .Width (64),
        .Depth (FQ_DEPTH)
    ) u_fetch_queue (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .flush_i (redirect),
        .push_i  (fq_push),
        .data_i  (fq_in),
        .pop_i   (fq_pop),
        .data_o  (fq_head),
        .count_o (fq_count)
    );

    assign fq_nonempty = (fq_count != '0);
    assign if_valid    = fq_nonempty & ~redirect;
    assign fq_pop      = if_valid & if_ready;
    assign if_pc       = fq_nonempty ? fq_head.pc : 32'h0;
    assign if_inst     = fq_nonempty ? fq_head.inst : FB_NOP_INST;

endmodule

// File: tb/tb_fb_fetch_unit.sv
// Self-checking bench for fb_fetch_unit with an in-order variable-latency memory model.
module tb_fb_fetch_unit;
    import fb_fetch_unit_pkg::*;

    localparam logic [31:0] RstPc = 32'h0000_0100;
    localparam int unsigned Depth = 4;

    logic        clk, rst_n;
    logic        address_src, predict_valid;
    logic [31:0] predict_err_pc, predict_pc;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        if_valid, if_ready;
    logic [31:0] if_pc, if_inst;

    fb_fetch_unit #(
        .RESET_PC (RstPc),
        .FQ_DEPTH (Depth)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .address_src    (address_src),
        .predict_err_pc (predict_err_pc),
        .predict_valid  (predict_valid),
        .predict_pc     (predict_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_inst        (if_inst),
        .if_ready       (if_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        logic        src;
        logic        pv;
        logic [31:0] err_pc;
        logic [31:0] pr_pc;
        int          lat;
        logic [31:0] exp;
    } vec_t;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          lat = 1;
    bit          rand_gnt = 0;
    int          g_cnt = 0;
    int          h_cnt = 0;
    mreq_t       mem_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] exp_fetch;
    logic        s_req, s_ifv, s_hs;
    logic [31:0] s_addr, s_ifpc, s_inst;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a ^ 32'hA5A5_0000) + 32'h0000_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: drive memory, sample at negedge, update scoreboard, return at posedge+1.
    task automatic cycle();
        logic        redir;
        logic [31:0] tgt, e;
        int          d;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mem_q[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        imem_gnt = rand_gnt ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        s_req  = imem_req;
        s_addr = imem_addr;
        s_ifv  = if_valid;
        s_ifpc = if_pc;
        s_inst = if_inst;
        redir  = rst_n & (address_src | predict_valid);
        tgt    = address_src ? predict_err_pc : predict_pc;
        if (imem_req && imem_gnt) begin
            check("fetch_addr", imem_addr, exp_fetch);
            exp_q.push_back(exp_fetch);
            d = (lat == 0) ? int'($urandom_range(1, 5)) : lat;
            mem_q.push_back('{imem_addr, cyc + d});
            exp_fetch = exp_fetch + 32'd1;
            g_cnt++;
        end
        if (imem_rvalid) void'(mem_q.pop_front());
        s_hs = if_valid & if_ready;
        if (s_hs) begin
            h_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_inst: got pc %h, expected no instruction", if_pc);
            end else begin
                e = exp_q.pop_front();
                check("if_pc", if_pc, e);
                check("if_inst", if_inst, mem_word(e));
            end
        end
        if (redir) begin
            check("redirect_gate", {30'b0, imem_req, if_valid}, 32'h0);
            exp_q.delete();
            exp_fetch = tgt;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before timeout");
        $fatal(1, "watchdog");
    end

    vec_t vecs[5];
    int   n;

    initial begin
        vecs[0] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0000_0999, 3, 32'h0000_0040};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0040, 32'h0000_0080, 3, 32'h0000_0040};
        vecs[2] = '{1'b0, 1'b1, 32'h0000_0055, 32'h0000_0080, 2, 32'h0000_0080};
        vecs[3] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1, 32'hFFFF_FFFF};
        vecs[4] = '{1'b0, 1'b1, 32'h0000_0000, 32'h0000_0200, 4, 32'h0000_0200};

        rst_n          = 1'b0;
        address_src    = 1'b0;
        predict_valid  = 1'b0;
        predict_err_pc = '0;
        predict_pc     = '0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        if_ready       = 1'b1;
        exp_fetch      = RstPc;
        @(posedge clk);
        #1;

        repeat (2) cycle();
        check("rst_req", s_req, 1'b0);
        check("rst_if_valid", s_ifv, 1'b0);
        check("rst_if_pc", s_ifpc, 32'h0);
        check("rst_if_inst", s_inst, FB_NOP_INST);

        rst_n = 1'b1;
        cycle();
        check("rel_req0", s_req, 1'b1);
        check("rel_addr0", s_addr, 32'h100);
        cycle();
        check("rel_addr1", s_addr, 32'h101);
        check("rel_ifv1", s_ifv, 1'b0);
        cycle();
        check("rel_addr2", s_addr, 32'h102);
        check("rel_ifv2", s_ifv, 1'b1);
        check("rel_ifpc2", s_ifpc, 32'h100);
        cycle();
        check("rel_ifpc3", s_ifpc, 32'h101);

        for (int i = 0; i < 5; i++) begin
            lat = vecs[i].lat;
            repeat (6) cycle();
            address_src    = vecs[i].src;
            predict_valid  = vecs[i].pv;
            predict_err_pc = vecs[i].err_pc;
            predict_pc     = vecs[i].pr_pc;
            cycle();
            check("vec_req_gated", s_req, 1'b0);
            check("vec_ifv_gated", s_ifv, 1'b0);
            address_src   = 1'b0;
            predict_valid = 1'b0;
            cycle();
            check("vec_req_next", s_req, 1'b1);
            check("vec_addr_next", s_addr, vecs[i].exp);
            n    = 0;
            s_hs = 1'b0;
            while (!s_hs && n < 40) begin
                cycle();
                n++;
            end
            if (!s_hs) begin
                checks++;
                errors++;
                $display("FAIL vec_first_timeout: got no if_valid, expected pc %h", vecs[i].exp);
            end else begin
                check("vec_first_pc", s_ifpc, vecs[i].exp);
            end
        end

        // Backpressure: after a flush at most Depth grants may issue.
        lat            = 1;
        if_ready       = 1'b0;
        address_src    = 1'b1;
        predict_err_pc = 32'h300;
        cycle();
        address_src = 1'b0;
        g_cnt       = 0;
        repeat (15) cycle();
        check("bp_grants", g_cnt, Depth);
        check("bp_req_low", s_req, 1'b0);
        if_ready = 1'b1;
        h_cnt    = 0;
        repeat (10) cycle();
        check("bp_drain", 32'(h_cnt >= 4), 32'd1);

        lat      = 0;
        rand_gnt = 1;
        h_cnt    = 0;
        for (int i = 0; i < 3000; i++) begin
            n              = int'($urandom_range(0, 99));
            if_ready       = ($urandom_range(0, 3) != 0);
            address_src    = (n < 4) || (n == 10);
            predict_valid  = (n >= 4 && n < 8) || (n == 10);
            predict_err_pc = $urandom;
            predict_pc     = $urandom;
            cycle();
        end
        address_src   = 1'b0;
        predict_valid = 1'b0;
        check("rand_progress", 32'(h_cnt > 100), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
